// File: rtl/vga_pkg.sv
// Shared types, default 1080p timing and colour helpers for the raster scan controller.
package vga_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef struct packed {
    logic [15:0] h_active;
    logic [15:0] h_fp;
    logic [15:0] h_sync;
    logic [15:0] h_bp;
    logic [15:0] v_active;
    logic [15:0] v_fp;
    logic [15:0] v_sync;
    logic [15:0] v_bp;
  } timing_t;

  // Per-stage video control bits carried alongside the VRAM read.
  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic vb;
  } stage_t;

  localparam int DEF_H_ACTIVE = 1920;
  localparam int DEF_H_FP     = 88;
  localparam int DEF_H_SYNC   = 44;
  localparam int DEF_H_BP     = 148;
  localparam int DEF_V_ACTIVE = 1080;
  localparam int DEF_V_FP     = 4;
  localparam int DEF_V_SYNC   = 5;
  localparam int DEF_V_BP     = 36;

  localparam timing_t DEF_TIMING = '{
    h_active: 16'(DEF_H_ACTIVE), h_fp: 16'(DEF_H_FP),
    h_sync:   16'(DEF_H_SYNC),   h_bp: 16'(DEF_H_BP),
    v_active: 16'(DEF_V_ACTIVE), v_fp: 16'(DEF_V_FP),
    v_sync:   16'(DEF_V_SYNC),   v_bp: 16'(DEF_V_BP)
  };

  function automatic int h_total(input timing_t t);
    return int'(t.h_active) + int'(t.h_fp) + int'(t.h_sync) + int'(t.h_bp);
  endfunction

  function automatic int v_total(input timing_t t);
    return int'(t.v_active) + int'(t.v_fp) + int'(t.v_sync) + int'(t.v_bp);
  endfunction

  // Replicate a BPP-bit pixel until it fills a 4-bit channel.
  function automatic logic [3:0] grey4(input logic [3:0] p, input int bpp);
    case (bpp)
      1:       return {4{p[0]}};
      2:       return {2{p[1:0]}};
      default: return p;
    endcase
  endfunction

  function automatic rgb444_t grey_rgb(input logic [3:0] p, input int bpp);
    logic [3:0] n;
    n = grey4(p, bpp);
    return '{r: n, g: n, b: n};
  endfunction

endpackage

// File: rtl/vga_palette.sv
// Writable 2^BPP-entry RGB444 palette; resets to a grey ramp, reads combinationally.
module vga_palette
  import vga_pkg::*;
#(
  parameter int BPP = 2
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           wen_i,
  input  logic [BPP-1:0] widx_i,
  input  logic [11:0]    wdata_i,
  input  logic [BPP-1:0] ridx_i,
  output rgb444_t        rdata_o
);

  localparam int N = 1 << BPP;

  rgb444_t pal_q [N];

  // Writes ignore the pixel enable so the CPU can update the palette at any time.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < N; i++) pal_q[i] <= grey_rgb(4'(i), BPP);
    end else if (wen_i) begin
      pal_q[widx_i] <= wdata_i;
    end
  end

  assign rdata_o = pal_q[ridx_i];

endmodule

// File: rtl/vga_scan_ctrl.sv
// Raster scan controller: programmable timing, scaled VRAM address, latency-aligned RGB444.
// Define VGA_SCAN_PALETTE_EN to map pixels through a writable palette instead of a grey ramp.
module vga_scan_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter int HS_POL      = 1,
  parameter int VS_POL      = 1,
  parameter int SCALE_SHIFT = 1,
  parameter int BPP         = 2,
  parameter int MEM_LAT     = 1,
  parameter int HA_W        = $clog2(H_ACTIVE >> SCALE_SHIFT),
  parameter int VA_W        = $clog2(V_ACTIVE >> SCALE_SHIFT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pix_en,
  output logic [VA_W+HA_W-1:0] vram_addr,
  input  logic [BPP-1:0]       vram_data,
  input  logic                 pal_wen,
  input  logic [BPP-1:0]       pal_idx,
  input  logic [11:0]          pal_rgb,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic                 vblank,
  output logic                 frame_start,
  output logic [3:0]           red,
  output logic [3:0]           green,
  output logic [3:0]           blue
);

  localparam timing_t TM = '{
    h_active: 16'(H_ACTIVE), h_fp: 16'(H_FP), h_sync: 16'(H_SYNC), h_bp: 16'(H_BP),
    v_active: 16'(V_ACTIVE), v_fp: 16'(V_FP), v_sync: 16'(V_SYNC), v_bp: 16'(V_BP)
  };

  localparam int H_TOTAL = h_total(TM);
  localparam int V_TOTAL = v_total(TM);
  localparam int HC_W    = $clog2(H_TOTAL);
  localparam int VC_W    = $clog2(V_TOTAL);
  localparam int HXW     = HC_W + 1;
  localparam int VXW     = VC_W + 1;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;
  localparam int L       = MEM_LAT + 1;

  logic [HC_W-1:0]      hc_q, hc_d;
  logic [VC_W-1:0]      vc_q, vc_d;
  logic [VA_W+HA_W-1:0] addr_q, addr_d;
  stage_t               s0;
  stage_t               pipe_q [1:L];
  rgb444_t              rgb_q, rgb_d;
  rgb444_t              map_rgb;
  logic                 act_nxt;
  logic [HXW-1:0]       hc_x;
  logic [VXW-1:0]       vc_x;

  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (pix_en) begin
      if (hc_q == HC_W'(H_TOTAL - 1)) begin
        hc_d = '0;
        vc_d = (vc_q == VC_W'(V_TOTAL - 1)) ? '0 : vc_q + VC_W'(1);
      end else begin
        hc_d = hc_q + HC_W'(1);
      end
    end
  end

  // Widened copies so the sync end bounds never overflow the counter width.
  assign hc_x = {1'b0, hc_q};
  assign vc_x = {1'b0, vc_q};

  always_comb begin
    s0     = '0;
    s0.act = (hc_q < HC_W'(H_ACTIVE)) && (vc_q < VC_W'(V_ACTIVE));
    s0.hs  = (hc_x >= HXW'(HS_BEG)) && (hc_x < HXW'(HS_END));
    s0.vs  = (vc_x >= VXW'(VS_BEG)) && (vc_x < VXW'(VS_END));
    s0.vb  = (vc_q >= VC_W'(V_ACTIVE));
  end

  // Address is computed from the next counter value so it lines up with stage 0;
  // outside the active area it freezes to avoid out-of-range reads.
  always_comb begin
    act_nxt = (hc_d < HC_W'(H_ACTIVE)) && (vc_d < VC_W'(V_ACTIVE));
    addr_d  = addr_q;
    if (act_nxt) addr_d = {VA_W'(vc_d >> SCALE_SHIFT), HA_W'(hc_d >> SCALE_SHIFT)};
  end

`ifdef VGA_SCAN_PALETTE_EN
  vga_palette #(.BPP(BPP)) u_pal (
    .clk_i   (clk),
    .rst_ni  (reset),
    .wen_i   (pal_wen),
    .widx_i  (pal_idx),
    .wdata_i (pal_rgb),
    .ridx_i  (vram_data),
    .rdata_o (map_rgb)
  );
`else
  logic unused_pal;
  assign unused_pal = ^{pal_wen, pal_idx, pal_rgb};
  assign map_rgb    = grey_rgb(4'(vram_data), BPP);
`endif

  // VRAM data for a pixel arrives together with stage L-1; the colour register makes it stage L.
  assign rgb_d = pipe_q[L-1].act ? map_rgb : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      hc_q   <= '0;
      vc_q   <= '0;
      addr_q <= '0;
      rgb_q  <= '0;
      for (int i = 1; i <= L; i++) pipe_q[i] <= '0;
    end else if (pix_en) begin
      hc_q      <= hc_d;
      vc_q      <= vc_d;
      addr_q    <= addr_d;
      rgb_q     <= rgb_d;
      pipe_q[1] <= s0;
      for (int i = 2; i <= L; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign vram_addr   = addr_q;
  assign hsync       = pipe_q[L].hs ^ (HS_POL == 0);
  assign vsync       = pipe_q[L].vs ^ (VS_POL == 0);
  assign de          = pipe_q[L].act;
  assign vblank      = pipe_q[L].vb;
  assign red         = rgb_q.r;
  assign green       = rgb_q.g;
  assign blue        = rgb_q.b;
  // Undelayed on purpose: drives the VRAM double-buffer swap.
  assign frame_start = reset && pix_en && (hc_q == '0) && (vc_q == '0);

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl: two small timing configurations checked every cycle against a positional model.
module tb_vga_scan_ctrl;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb, sh, bpp, lat, hpol, vpol, haw;
  } cfg_t;

  typedef struct {
    logic        hs, vs, de, vb, fs;
    logic [11:0] rgb;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic en    = 1'b1;
  logic chk   = 1'b0;
  int   checks = 0;
  int   errs   = 0;

  cfg_t ca = '{8, 2, 2, 2, 4, 1, 1, 1, 0, 2, 1, 1, 1, 3};
  cfg_t cb = '{16, 2, 3, 3, 8, 1, 2, 1, 1, 1, 2, 0, 1, 3};

  int na = 0, nb = 0, la = 0, lb = 0;

  logic [4:0]  vaddr_a, vaddr_b;
  logic [1:0]  vdata_a;
  logic [0:0]  vdata_b;
  logic        hs_a, vs_a, de_a, vb_a, fs_a;
  logic        hs_b, vs_b, de_b, vb_b, fs_b;
  logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  logic        pal_wen = 1'b0;
  logic [1:0]  pidx_a  = '0;
  logic [0:0]  pidx_b  = '0;
  logic [11:0] pal_rgb = '0;

  vga_scan_ctrl #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1), .VS_POL(1), .SCALE_SHIFT(0), .BPP(2), .MEM_LAT(1)
  ) u_a (
    .clk(clk), .reset(rst_n), .pix_en(en), .vram_addr(vaddr_a), .vram_data(vdata_a),
    .pal_wen(pal_wen), .pal_idx(pidx_a), .pal_rgb(pal_rgb),
    .hsync(hs_a), .vsync(vs_a), .de(de_a), .vblank(vb_a), .frame_start(fs_a),
    .red(r_a), .green(g_a), .blue(b_a)
  );

  vga_scan_ctrl #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(0), .VS_POL(1), .SCALE_SHIFT(1), .BPP(1), .MEM_LAT(2)
  ) u_b (
    .clk(clk), .reset(rst_n), .pix_en(en), .vram_addr(vaddr_b), .vram_data(vdata_b),
    .pal_wen(pal_wen), .pal_idx(pidx_b), .pal_rgb(pal_rgb),
    .hsync(hs_b), .vsync(vs_b), .de(de_b), .vblank(vb_b), .frame_start(fs_b),
    .red(r_b), .green(g_b), .blue(b_b)
  );

  function automatic bit act_of(input cfg_t c, input int n);
    int ht, vt, h, v;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    h  = n % ht;
    v  = (n / ht) % vt;
    return (h < c.ha) && (v < c.va);
  endfunction

  function automatic int addr_of(input cfg_t c, input int n);
    int ht, vt, h, v;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    h  = n % ht;
    v  = (n / ht) % vt;
    return ((v >> c.sh) << c.haw) | (h >> c.sh);
  endfunction

  // Outputs after n enabled cycles since reset describe raster position n-(lat+1).
  function automatic exp_t model_out(input cfg_t c, input int n, input logic rn, input logic e_in);
    exp_t e;
    int ht, vt, p, h, v, pix, g;
    bit hp, vp;
    ht    = c.ha + c.hf + c.hs + c.hb;
    vt    = c.va + c.vf + c.vs + c.vb;
    hp    = (c.hpol != 0);
    vp    = (c.vpol != 0);
    p     = n - (c.lat + 1);
    e.hs  = !hp;
    e.vs  = !vp;
    e.de  = 1'b0;
    e.vb  = 1'b0;
    e.rgb = 12'h000;
    e.fs  = rn && e_in && (n % (ht * vt) == 0);
    if (p >= 0) begin
      h    = p % ht;
      v    = (p / ht) % vt;
      e.hs = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) ? hp : !hp;
      e.vs = (v >= c.va + c.vf && v < c.va + c.vf + c.vs) ? vp : !vp;
      e.de = (h < c.ha) && (v < c.va);
      e.vb = (v >= c.va);
      if (e.de) begin
        pix   = (h >> c.sh) % (1 << c.bpp);
        g     = pix * 15 / ((1 << c.bpp) - 1);
        e.rgb = {g[3:0], g[3:0], g[3:0]};
      end
    end
    return e;
  endfunction

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // VRAM models: data = low address bits, returned after MEM_LAT enabled edges.
  // Config B returns all ones for addresses fetched outside the active area.
  logic [4:0] am_a [4];
  logic [4:0] am_b [4];
  bit         ok_b [4];

  assign vdata_a = am_a[0][1:0];
  assign vdata_b = ok_b[1] ? am_b[1][0:0] : 1'b1;

  always @(posedge clk) begin
    int nna, nnb;
    if (en) begin
      am_a[0] <= vaddr_a;
      am_b[0] <= vaddr_b;
      ok_b[0] <= act_of(cb, nb);
      for (int i = 1; i < 4; i++) begin
        am_a[i] <= am_a[i-1];
        am_b[i] <= am_b[i-1];
        ok_b[i] <= ok_b[i-1];
      end
    end
    nna = !rst_n ? 0 : (en ? na + 1 : na);
    nnb = !rst_n ? 0 : (en ? nb + 1 : nb);
    na <= nna;
    nb <= nnb;
    if (act_of(ca, nna)) la <= addr_of(ca, nna);
    if (act_of(cb, nnb)) lb <= addr_of(cb, nnb);
  end

  always @(negedge clk) begin
    exp_t e;
    if (chk) begin
      e = model_out(ca, na, rst_n, en);
      cmp("A.hsync", 16'(hs_a), 16'(e.hs));
      cmp("A.vsync", 16'(vs_a), 16'(e.vs));
      cmp("A.de", 16'(de_a), 16'(e.de));
      cmp("A.vblank", 16'(vb_a), 16'(e.vb));
      cmp("A.frame_start", 16'(fs_a), 16'(e.fs));
      cmp("A.rgb", 16'({r_a, g_a, b_a}), 16'(e.rgb));
      cmp("A.addr", 16'(vaddr_a), 16'(la));
      e = model_out(cb, nb, rst_n, en);
      cmp("B.hsync", 16'(hs_b), 16'(e.hs));
      cmp("B.vsync", 16'(vs_b), 16'(e.vs));
      cmp("B.de", 16'(de_b), 16'(e.de));
      cmp("B.vblank", 16'(vb_b), 16'(e.vb));
      cmp("B.frame_start", 16'(fs_b), 16'(e.fs));
      cmp("B.rgb", 16'({r_b, g_b, b_b}), 16'(e.rgb));
      cmp("B.addr", 16'(vaddr_b), 16'(lb));
      if (rst_n) begin
        case (na)
          1:  cmp("A.lit_de_n1", 16'(de_a), 16'd0);
          2:  cmp("A.lit_de_n2", 16'(de_a), 16'd1);
          4:  cmp("A.lit_rgb_aaa", 16'({r_a, g_a, b_a}), 16'hAAA);
          9:  cmp("A.lit_de_n9", 16'(de_a), 16'd1);
          10: cmp("A.lit_de_n10", 16'(de_a), 16'd0);
          11: cmp("A.lit_hs_n11", 16'(hs_a), 16'd0);
          12: cmp("A.lit_hs_n12", 16'(hs_a), 16'd1);
          13: cmp("A.lit_hs_n13", 16'(hs_a), 16'd1);
          14: cmp("A.lit_hs_n14", 16'(hs_a), 16'd0);
          57: cmp("A.lit_vb_n57", 16'(vb_a), 16'd0);
          58: cmp("A.lit_vb_n58", 16'(vb_a), 16'd1);
          71: cmp("A.lit_vs_n71", 16'(vs_a), 16'd0);
          72: cmp("A.lit_vs_n72", 16'(vs_a), 16'd1);
          97: cmp("A.lit_fs_n97", 16'(fs_a), 16'd0);
          98: if (en) cmp("A.lit_fs_n98", 16'(fs_a), 16'd1);
          default: ;
        endcase
        case (nb)
          2:  cmp("B.lit_addr_n2", 16'(vaddr_b), 16'd1);
          3:  cmp("B.lit_rgb_n3", 16'({r_b, g_b, b_b}), 16'h000);
          5:  cmp("B.lit_rgb_n5", 16'({r_b, g_b, b_b}), 16'hFFF);
          19: cmp("B.lit_rgb_blank", 16'({r_b, g_b, b_b}), 16'h000);
          20: cmp("B.lit_hs_n20", 16'(hs_b), 16'd1);
          21: cmp("B.lit_hs_n21", 16'(hs_b), 16'd0);
          48: cmp("B.lit_addr_line2", 16'(vaddr_b), 16'd8);
          50: cmp("B.lit_addr_n50", 16'(vaddr_b), 16'd9);
          default: ;
        endcase
      end
    end
  end

  initial begin
    // Reset with pix_en high, then a tied-high run.
    repeat (2) @(posedge clk);
    #1 chk = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (300) @(posedge clk);

    // pix_en toggling 1,0,1,0 from a fresh reset.
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1 en = ~en;
    end

    // Reset asserted mid-frame with B at hc=5, vc=3.
    en = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (77) @(posedge clk);
    #2 cmp("B.pre_rst_addr", 16'(vaddr_b), 16'd10);
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    cmp("B.rst_addr", 16'(vaddr_b), 16'd0);
    cmp("B.rst_de", 16'(de_b), 16'd0);
    cmp("B.rst_rgb", 16'({r_b, g_b, b_b}), 16'h000);
    cmp("B.rst_hsync", 16'(hs_b), 16'd1);
    cmp("B.rst_vsync", 16'(vs_b), 16'd0);
    cmp("B.rst_fs", 16'(fs_b), 16'd0);
    cmp("A.rst_addr", 16'(vaddr_a), 16'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    cmp("A.post_rst_fs", 16'(fs_a), 16'd1);
    cmp("B.post_rst_fs", 16'(fs_b), 16'd1);
    repeat (40) @(posedge clk);
    #1 chk = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule

// File: doc/vga_scan_ctrl.md
Name: vga_scan_ctrl

Overview:
- Parametrised raster scan controller for the OTTER video path. Generates programmable VGA/HDMI-style timing and the scaled framebuffer read address.
- Accepts pixel data from an external synchronous VRAM read port with configurable read latency. Maps each pixel to RGB444 and outputs it aligned with sync and blank.
- Generalises the fixed 960x540, 2-bpp, 1080p driver to any resolution, integer power-of-2 scale, pixel depth and memory latency. Adds a pixel-clock enable, a frame-start strobe and an optional writable palette.

Parameters:
- H_ACTIVE, 1920, visible pixels per line
- H_FP, 88, horizontal front porch
- H_SYNC, 44, hsync width
- H_BP, 148, horizontal back porch
- V_ACTIVE, 1080, visible lines
- V_FP, 4, vertical front porch
- V_SYNC, 5, vsync width
- V_BP, 36, vertical back porch
- HS_POL, 1, hsync active level
- VS_POL, 1, vsync active level
- SCALE_SHIFT, 1, log2 of pixel replication factor in x and y
- BPP, 2, bits per pixel; legal values 1, 2, 4
- MEM_LAT, 1, VRAM read latency in enabled cycles; 1..4
- HA_W, $clog2(H_ACTIVE>>SCALE_SHIFT), horizontal address width (derived)
- VA_W, $clog2(V_ACTIVE>>SCALE_SHIFT), vertical address width (derived)

Ports:
- clk  in  1  pixel-domain clock
- reset  in  1  synchronous, active-low reset
- pix_en  in  1  pixel-rate enable; state advances only when high
- vram_addr  out  VA_W+HA_W  read address {line, column}
- vram_data  in  BPP  pixel returned MEM_LAT enabled cycles after address
- pal_wen  in  1  palette write strobe
- pal_idx  in  BPP  palette entry
- pal_rgb  in  12  palette value {r,g,b}
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  active video
- vblank  out  1  high when line >= V_ACTIVE
- frame_start  out  1  one-clk pulse at h=0, v=0
- red, green, blue  out  4 each  pixel colour

Behaviour:
- Constants: H_TOTAL = sum of the H_* parameters; V_TOTAL likewise.
- Horizontal counter: hc in [0, H_TOTAL-1]. Vertical counter: vc in [0, V_TOTAL-1].
- When pix_en is high, hc increments. At hc = H_TOTAL-1, hc wraps to 0 and vc increments; vc wraps at V_TOTAL-1.
- When pix_en is low, all registers hold, including the pipeline; frame_start is forced 0.
- Raw (stage 0) signals:
  - act = hc < H_ACTIVE and vc < V_ACTIVE.
  - hs_raw active for H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw active for V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC.
- vram_addr is registered, = {vc>>SCALE_SHIFT, hc>>SCALE_SHIFT} truncated to VA_W/HA_W. It is held at its last active value while act = 0, so no out-of-range reads occur.
- act, hs_raw, vs_raw and vblank pass through a shift pipeline of L = MEM_LAT+1 enabled stages. The extra stage is the colour-map register.
- hsync, vsync, de, vblank and rgb are therefore all mutually aligned, lagging the counters by L.
- Colour map: rgb = map(vram_data) when the delayed act is high, else 12'h000.
- frame_start is combinational from the counters (hc=0, vc=0, pix_en high), not delayed. It is used for VRAM double-buffer swap.
- Reset values:
  - hc = vc = 0, vram_addr = 0.
  - Pipeline cleared; hsync = !HS_POL, vsync = !VS_POL.
  - de = 0, vblank = 0, rgb = 0, frame_start = 0.
- Reset asserted mid-frame: all of the above on the next clk edge, regardless of pix_en. The first frame_start occurs in the first enabled cycle after release.

Optional Feature:
- Macro: VGA_SCAN_PALETTE_EN.
- Defined: 2^BPP x 12-bit palette register file.
  - Reset contents: grey ramp, entry i = {3{i replicated to 4 bits}}.
  - Write on clk when pal_wen = 1, independent of pix_en.
  - A write and a read of the same index in one cycle returns the old value; the new value is visible from the next cycle.
- Undefined: map(p) = p replicated 4/BPP times into each channel, giving grey. pal_* inputs are ignored but the ports remain.

Decomposition:
- Package vga_pkg holds:
  - rgb444_t packed struct {r,g,b}.
  - Default 1080p timing localparams.
  - A timing_t struct bundling the H/V porch values.
  - A function for grey replication.
- One sub-module, vga_palette (register file plus read mux), instantiated only under the macro.

Test Plan:
- Small timing (H 8/2/2/2, V 4/1/1/1, SCALE_SHIFT 0, MEM_LAT 1) with pix_en tied high:
  - hsync active exactly at hc 10..11.
  - vsync on line 5.
  - frame_start every 14*7 = 98 clks.
  - de high for 8 of every 14 clks, lagging hc by 2.
- Default parameters with a VRAM model returning address bits as data:
  - vram_addr sequence on line 0 is 0,0,1,1,...
  - line 2 has line field 1.
  - rgb matches data 2 clks later.
- pix_en toggling 1,0,1,0: counters advance only on enabled cycles; outputs are identical to the tied-high run, stretched 2x.
- reset driven low at hc=500, vc=300:
  - Next edge gives hc = vc = 0, de = 0, rgb = 0, sync inactive.
  - After release, frame_start fires on the first enabled cycle.
- With VGA_SCAN_PALETTE_EN defined:
  - Write idx 2 = 12'hF00 while displaying index 2: red = F from the following pixel.
  - Without the macro: pixel 2'b10 gives rgb = 12'hAAA.
- Blanking: a VRAM model driving all ones during blank gives rgb = 0 whenever de = 0; vblank is high exactly while aligned vc >= V_ACTIVE.
